// File: rtl/security_input_pkg.sv
// Shared constants for the security-system switch inputs: channel mode encoding
// and synchroniser depth.
package security_input_pkg;

  localparam logic MODE_TOGGLE    = 1'b0;
  localparam logic MODE_MOMENTARY = 1'b1;
  localparam int   SYNC_STAGES    = 2;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: SYNC_STAGES-flop synchroniser feeding a debounce counter.
// o_Filt changes SYNC_STAGES+DEBOUNCE_CYCLES edges after a clean raw edge; no backpressure.
module debounce_channel
  import security_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_Clk,
  input  logic i_Reset_n,
  input  logic i_Switch,
  output logic o_Filt
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   filt_q, filt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_Switch};
    filt_d = filt_q;
    cnt_d  = cnt_q;
    // Any sample agreeing with the filtered level restarts the stability window.
    if (sync_out == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      filt_d = sync_out;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_Filt = filt_q;

endmodule

// File: rtl/multi_toggle_input.sv
// N-channel debounced arm/zone switch input, toggle or momentary per channel; raw edge to
// o_State/o_Event is DEBOUNCE_CYCLES+3 edges, no backpressure. LONG_PRESS_CLEAR_EN adds long-press clear.
module multi_toggle_input
  import security_input_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LONG_CYCLES     = 2500000
) (
  input  logic              i_Clk,
  input  logic              i_Reset_n,
  input  logic [NUM_CH-1:0] i_Switch,
  input  logic [NUM_CH-1:0] i_Mode,
  input  logic              i_Clear,
  output logic [NUM_CH-1:0] o_State,
  output logic [NUM_CH-1:0] o_Event
);

  if (NUM_CH < 1 || NUM_CH > 16 || DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_param_check
    $error("multi_toggle_input: illegal parameter set");
  end

  logic [NUM_CH-1:0] filt;
  logic [NUM_CH-1:0] release_w;
  logic [NUM_CH-1:0] prev_q, prev_d;
  logic [NUM_CH-1:0] state_q, state_d;
  logic [NUM_CH-1:0] event_q, event_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .i_Clk    (i_Clk),
      .i_Reset_n(i_Reset_n),
      .i_Switch (i_Switch[g]),
      .o_Filt   (filt[g])
    );
  end

  assign release_w = prev_q & ~filt;

`ifdef LONG_PRESS_CLEAR_EN
  localparam int               HOLD_W    = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q [NUM_CH];
  logic [HOLD_W-1:0] hold_d [NUM_CH];
  logic [NUM_CH-1:0] suppress_q, suppress_d;
`endif

  always_comb begin
    prev_d  = filt;
    state_d = state_q;
`ifdef LONG_PRESS_CLEAR_EN
    suppress_d = suppress_q;
    for (int i = 0; i < NUM_CH; i++) hold_d[i] = '0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      case (i_Mode[i])
        MODE_MOMENTARY: state_d[i] = filt[i];
        MODE_TOGGLE: begin
`ifdef LONG_PRESS_CLEAR_EN
          if (filt[i]) hold_d[i] = (hold_q[i] == HOLD_MAX) ? HOLD_MAX : hold_q[i] + 1'b1;
          // A release that ends a long press only re-arms the channel.
          if (release_w[i]) begin
            if (suppress_q[i]) suppress_d[i] = 1'b0;
            else               state_d[i]    = ~state_q[i];
          end
          if (filt[i] && hold_q[i] == HOLD_FIRE) begin
            state_d[i]    = 1'b0;
            suppress_d[i] = 1'b1;
          end
`else
          if (release_w[i]) state_d[i] = ~state_q[i];
`endif
        end
        default: state_d[i] = state_q[i];
      endcase
    end
    if (i_Clear) state_d = '0;
    event_d = state_d ^ state_q;
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      prev_q  <= '0;
      state_q <= '0;
      event_q <= '0;
`ifdef LONG_PRESS_CLEAR_EN
      suppress_q <= '0;
      for (int i = 0; i < NUM_CH; i++) hold_q[i] <= '0;
`endif
    end else begin
      prev_q  <= prev_d;
      state_q <= state_d;
      event_q <= event_d;
`ifdef LONG_PRESS_CLEAR_EN
      suppress_q <= suppress_d;
      for (int i = 0; i < NUM_CH; i++) hold_q[i] <= hold_d[i];
`endif
    end
  end

  assign o_State = state_q;
  assign o_Event = event_q;

endmodule

// File: tb/tb_multi_toggle_input.sv
// Scoreboard bench for multi_toggle_input (NUM_CH=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=20).
// Stimulus queues expected (cycle, state, event) tuples; the monitor checks each o_Event pulse.
module tb_multi_toggle_input;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw;
  logic [3:0] mode;
  logic       clr;
  logic [3:0] o_State;
  logic [3:0] o_Event;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         at;
    logic [3:0] st;
    logic [3:0] ev;
  } exp_t;

  exp_t exp_q[$];

  multi_toggle_input #(
    .NUM_CH         (4),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20)
  ) dut (
    .i_Clk    (clk),
    .i_Reset_n(rst_n),
    .i_Switch (sw),
    .i_Mode   (mode),
    .i_Clear  (clr),
    .o_State  (o_State),
    .o_Event  (o_Event)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int at, input logic [3:0] st, input logic [3:0] ev);
    exp_t e;
    e.at = at;
    e.st = st;
    e.ev = ev;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every event pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && o_Event != 4'b0000) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got event %b state %b at cycle %0d, none required", o_Event, o_State, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event_cycle", cyc, e.at);
        check("event_bits", o_Event, e.ev);
        check("event_state", o_State, e.st);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    sw    = 4'b0000;
    mode  = 4'b0000;
    clr   = 1'b0;
    tick(2);
    check("reset_state", o_State, 4'b0000);
    check("reset_event", o_Event, 4'b0000);
    rst_n = 1'b1;
    tick(3);

    // Ch0 toggle: press does nothing, release toggles 7 edges later.
    sw[0] = 1'b1;
    tick(10);
    sw[0] = 1'b0;
    expect_ev(cyc + 7, 4'b0001, 4'b0001);
    tick(12);
    check("s1_state_set", o_State, 4'b0001);
    sw[0] = 1'b1;
    tick(10);
    sw[0] = 1'b0;
    expect_ev(cyc + 7, 4'b0000, 4'b0001);
    tick(12);
    check("s1_state_clr", o_State, 4'b0000);

    // Ch1 bouncy release: transitions every 2 cycles, final low at t=12.
    sw[1] = 1'b1;
    tick(6);
    for (int k = 0; k < 7; k++) begin
      sw[1] = ~sw[1];
      if (k < 6) tick(2);
    end
    expect_ev(cyc + 7, 4'b0010, 4'b0010);
    tick(12);
    check("s2_state", o_State, 4'b0010);

    // Ch2 momentary: follows the filtered level at both ends.
    mode[2] = 1'b1;
    tick(2);
    sw[2] = 1'b1;
    expect_ev(cyc + 7, 4'b0110, 4'b0100);
    tick(15);
    sw[2] = 1'b0;
    expect_ev(cyc + 7, 4'b0010, 4'b0100);
    tick(10);
    check("s3_state", o_State, 4'b0010);

    // Simultaneous releases on ch0/ch3, then clear colliding with ch2 release.
    mode[2] = 1'b0;
    tick(2);
    check("s4_mode_hold", o_State, 4'b0010);
    sw[0] = 1'b1;
    sw[3] = 1'b1;
    tick(10);
    sw[0] = 1'b0;
    sw[3] = 1'b0;
    expect_ev(cyc + 7, 4'b1011, 4'b1001);
    tick(10);
    check("s4_state_1011", o_State, 4'b1011);
    sw[2] = 1'b1;
    tick(10);
    sw[2] = 1'b0;
    tick(6);
    clr = 1'b1;
    expect_ev(cyc + 1, 4'b0000, 4'b1011);
    tick(1);
    clr = 1'b0;
    tick(10);
    check("s4_state_cleared", o_State, 4'b0000);

    // Asynchronous reset mid-debounce, then a too-short press.
    sw[3] = 1'b1;
    tick(10);
    sw[3] = 1'b0;
    expect_ev(cyc + 7, 4'b1000, 4'b1000);
    tick(10);
    check("s5_state_pre", o_State, 4'b1000);
    sw[0] = 1'b1;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    check("s5_async_state", o_State, 4'b0000);
    check("s5_async_event", o_Event, 4'b0000);
    sw[0] = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    sw[0] = 1'b1;
    tick(3);
    sw[0] = 1'b0;
    tick(15);
    check("s5_short_press", o_State, 4'b0000);

`ifdef LONG_PRESS_CLEAR_EN
    // Long press on a set toggle channel clears it; the release does not toggle.
    sw[0] = 1'b1;
    tick(10);
    sw[0] = 1'b0;
    expect_ev(cyc + 7, 4'b0001, 4'b0001);
    tick(10);
    sw[0] = 1'b1;
    expect_ev(cyc + 26, 4'b0000, 4'b0001);
    tick(30);
    sw[0] = 1'b0;
    tick(15);
    check("s6_long_press", o_State, 4'b0000);
`endif

    tick(5);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_toggle_input.md
Name: multi_toggle_input

Overview:
N-channel successor to the single-switch toggle input, used for the security system's arm/zone switches. Each channel has:
- a 2-flop synchroniser
- a parametrised debounce counter
- release-edge detection
- a per-channel mode: latched toggle or momentary pass-through

A one-cycle change-event pulse per channel feeds the alarm controller. A global synchronous clear is provided.

Parameters:
NUM_CH, 4, number of independent switch channels (1..16)
DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before the filtered level changes (>=2)
LONG_CYCLES, 2500000, hold duration for long-press clear; used only with the optional feature (>DEBOUNCE_CYCLES)

Ports:
i_Clk  input  1  system clock
i_Reset_n  input  1  asynchronous, active-low reset
i_Switch  input  NUM_CH  raw asynchronous switch levels, 1 = pressed
i_Mode  input  NUM_CH  per-channel mode: 0 = toggle, 1 = momentary
i_Clear  input  1  synchronous clear of all latched states
o_State  output  NUM_CH  per-channel output state
o_Event  output  NUM_CH  one-cycle pulse when the corresponding o_State bit changes

Behaviour:
- One clock domain: i_Clk. Reset is asynchronous and active-low (i_Reset_n).
- While reset is asserted, all of the following are 0: synchroniser flops, filtered levels, previous-filtered registers, debounce and hold counters, o_State, o_Event.
- Reset mid-debounce discards the partial count.
- Synchroniser: raw -> s1 -> s2, 2 cycles of latency.
- Debounce, per channel:
  - If s2 == filt: cnt <= 0.
  - Else, if cnt == DEBOUNCE_CYCLES-1: filt <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any bounce resets the count.
  - Counter width is $clog2(DEBOUNCE_CYCLES).
- Edge detect: prev <= filt each cycle. Release = prev & ~filt.
- Toggle mode: o_State[i] inverts on the cycle after release. Press does not toggle.
- Momentary mode: o_State[i] <= filt, so o_State follows filt with one cycle of latency.
- End-to-end latency: a clean raw transition is reflected in o_State exactly DEBOUNCE_CYCLES+3 clock edges later.
- o_Event[i] <= (next o_State[i] != o_State[i]). It is registered and aligned with the o_State update.
- i_Clear, sampled high:
  - All o_State bits go to 0 next cycle. o_Event pulses only for bits that were 1.
  - Clear wins over a simultaneous release or momentary level.
  - Debounce state is not affected.
- Mode change: o_State keeps its current value.
  - Toggle -> momentary: o_State follows filt from the next cycle.
  - Momentary -> toggle: state holds until the next release.
- Channels are fully independent. Simultaneous releases on several channels all take effect in the same cycle.

Optional Feature:
Macro LONG_PRESS_CLEAR_EN.
- Defined: each toggle-mode channel has a hold counter.
  - The counter increments while filt == 1 and saturates at LONG_CYCLES.
  - On reaching LONG_CYCLES-1: o_State[i] <= 0, o_Event pulses if the bit was 1, and a suppress flag is set.
  - The next release clears the suppress flag and does not toggle.
  - The hold counter resets whenever filt == 0.
  - Momentary channels ignore the feature.
- Undefined: no hold counters or suppress flags exist, and every release toggles.

Decomposition:
- Package security_input_pkg:
  - MODE_TOGGLE = 1'b0, MODE_MOMENTARY = 1'b1
  - shared SYNC_STAGES = 2 constant
- Sub-module debounce_channel: synchroniser plus debounce counter for one channel (inputs i_Clk, i_Reset_n, i_Switch; output o_Filt). It is instantiated NUM_CH times in a generate loop.
- Edge detection, mode muxing, clear and long-press logic stay in the top module.

Test Plan:
All scenarios use NUM_CH=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
1. Ch0 toggle mode: press for 10 cycles, then release -> o_State[0] rises exactly 7 edges after the release edge, with o_Event[0] a single-cycle pulse. A second press/release returns it to 0.
2. Bounce: ch1 release toggling every 2 cycles for 12 cycles, then stable -> exactly one toggle, 7 edges after the last transition. No o_Event during the bounce.
3. Ch2 momentary: hold pressed for 15 cycles -> o_State[2] high from 7 edges after press until 7 edges after release. o_Event pulses at both ends.
4. Clear collision: o_State = 4'b1011, i_Clear asserted on the same cycle ch2's release would toggle -> o_State = 4'b0000 next cycle, o_Event = 4'b1011.
5. Reset: assert i_Reset_n=0 asynchronously mid-count and mid-hold -> o_State = 0 and o_Event = 0 immediately. After release, a 3-cycle press does not register.
6. With LONG_PRESS_CLEAR_EN: ch0 at 1, hold pressed 30 cycles -> o_State[0] clears 20 cycles after filt rises, with one o_Event pulse. The subsequent release leaves it at 0.
